// File: rtl/row_feed_ctrl_pkg.sv
// Shared types and default sizes for the row feed controller.
// Imported by the buffer and by the controller top.
package row_feed_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ROW_WIDTH  = 5;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        ROTATE  = 2'd2,
        DONE    = 2'd3
    } feed_state_e;

    typedef struct packed {
        logic in_ready;
        logic load;
        logic shift;
        logic busy;
        logic done;
    } feed_ctrl_t;

endpackage

// File: rtl/row_collect_buf.sv
// Write-indexed row buffer: stores elements in arrival order and
// flags the write that completes a row.
module row_collect_buf
    import row_feed_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROW_WIDTH  = DEFAULT_ROW_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] row [ROW_WIDTH],
    output logic                  full
);

    localparam int IDX_W = $clog2(ROW_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_WIDTH - 1);

    logic [IDX_W-1:0] wr_idx;

    assign full = wr_en && (wr_idx == LAST_IDX);

    // Write pointer: advances per accepted element, wraps after the last slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
        end else if (wr_en) begin
            wr_idx <= full ? '0 : wr_idx + IDX_W'(1);
        end
    end

    // Element storage: only the addressed slot changes on a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROW_WIDTH; i++) begin
                row[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROW_WIDTH; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    row[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/row_feed_ctrl.sv
// Collects a row of elements, strobes it into a downstream shifting
// row, then issues the requested number of rotation steps.
module row_feed_ctrl
    import row_feed_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROW_WIDTH  = DEFAULT_ROW_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    input  logic [$clog2(ROW_WIDTH)-1:0] rot_count,
    output logic                         parallel_load_en,
    output logic [DATA_WIDTH-1:0]        parallel_idata [ROW_WIDTH],
    output logic                         shifting_enable,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = $clog2(ROW_WIDTH);
    localparam logic [IDX_W:0] ROW_LEN = (IDX_W + 1)'(ROW_WIDTH);

    feed_state_e      state_q;
    feed_state_e      state_d;
    feed_ctrl_t       ctrl;
    logic [IDX_W-1:0] rot_rem;
    logic [IDX_W-1:0] rot_mod;
    logic [IDX_W:0]   rot_ext;
    logic             wr_en;
    logic             row_full;

    assign wr_en = in_valid && ctrl.in_ready;

    row_collect_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .row     (parallel_idata),
        .full    (row_full)
    );

    // rot_count never reaches 2*ROW_WIDTH, so one conditional subtract is a full modulo.
    always_comb begin
        rot_ext = {1'b0, rot_count};
        if (rot_ext >= ROW_LEN) begin
            rot_ext = rot_ext - ROW_LEN;
        end
        rot_mod = rot_ext[IDX_W-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output decode from the registered state.
    always_comb begin
        state_d       = state_q;
        ctrl.in_ready = 1'b0;
        ctrl.load     = 1'b0;
        ctrl.shift    = 1'b0;
        ctrl.busy     = 1'b1;
        ctrl.done     = 1'b0;
        unique case (state_q)
            COLLECT: begin
                ctrl.in_ready = 1'b1;
                ctrl.busy     = 1'b0;
                if (row_full) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ctrl.load = 1'b1;
                state_d   = (rot_mod != '0) ? ROTATE : DONE;
            end
            ROTATE: begin
                ctrl.shift = 1'b1;
                if (rot_rem == IDX_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ctrl.done = 1'b1;
                state_d   = COLLECT;
            end
        endcase
    end

    // Remaining rotations: captured in LOAD, counted down while rotating.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_rem <= '0;
        end else if (ctrl.load) begin
            rot_rem <= rot_mod;
        end else if (ctrl.shift) begin
            rot_rem <= rot_rem - IDX_W'(1);
        end
    end

    assign in_ready         = ctrl.in_ready;
    assign parallel_load_en = ctrl.load;
    assign shifting_enable  = ctrl.shift;
    assign busy             = ctrl.busy;
    assign done             = ctrl.done;

endmodule

// File: tb/tb_row_feed_ctrl.sv
// Scoreboard bench for row_feed_ctrl: stimulus side predicts rows and
// rotations; a negedge monitor checks load/shift/done against them.
module tb_row_feed_ctrl;

    localparam int ROW_W = 5;

    typedef struct {
        logic [ROW_W-1:0][7:0] row;
        int                    k;
        int                    load_cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] rot_count;
    logic       load_en;
    logic [7:0] idata [ROW_W];
    logic       shift_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t       sb [$];
    logic [7:0] elems [$];
    logic [ROW_W-1:0][7:0] pend_row;
    int         blocked   = 0;
    logic       load_next = 1'b0;

    exp_t       cur;
    logic       mon_active = 1'b0;
    int         shifts;
    logic [7:0] dr [ROW_W];

    row_feed_ctrl #(
        .DATA_WIDTH (8),
        .ROW_WIDTH  (ROW_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .rot_count        (rot_count),
        .parallel_load_en (load_en),
        .parallel_idata   (idata),
        .shifting_enable  (shift_en),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d", name, cyc);
    endtask

    // Monitor: pops an expected row on each load and follows it to done.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            checks++;
            if (load_en && shift_en) begin
                errors++;
                $display("FAIL overlap load=1 shift=1 cyc=%0d", cyc);
            end
            if (load_en) begin
                if (mon_active) flag("load_while_active");
                if (sb.size() == 0) begin
                    flag("spurious_load");
                end else begin
                    cur = sb.pop_front();
                    chk("load_cycle", cyc, cur.load_cyc);
                    for (int i = 0; i < ROW_W; i++) begin
                        chk("load_data", idata[i], cur.row[i]);
                        dr[i] = idata[i];
                    end
                    shifts     = 0;
                    mon_active = 1'b1;
                end
            end else if (shift_en) begin
                if (!mon_active) begin
                    flag("spurious_shift");
                end else begin
                    logic [7:0] t;
                    shifts++;
                    t = dr[ROW_W-1];
                    for (int i = ROW_W - 1; i > 0; i--) dr[i] = dr[i-1];
                    dr[0] = t;
                    for (int i = 0; i < ROW_W; i++)
                        chk("idata_stable", idata[i], cur.row[i]);
                end
            end else if (done) begin
                if (!mon_active) begin
                    flag("spurious_done");
                end else begin
                    chk("shift_count", shifts, cur.k);
                    chk("done_cycle", cyc, cur.load_cyc + 1 + cur.k);
                    for (int i = 0; i < ROW_W; i++) begin
                        chk("rotated_row", dr[i],
                            cur.row[(i - cur.k + ROW_W) % ROW_W]);
                        chk("idata_stable", idata[i], cur.row[i]);
                    end
                    mon_active = 1'b0;
                end
            end else if (mon_active) begin
                flag("gap_before_done");
                mon_active = 1'b0;
            end
        end
    end

    // One clock of stimulus; the model tracks acceptance and blocking.
    task automatic cycle(input logic v, input logic [7:0] d,
                         input logic [2:0] rc, output logic acc);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        rot_count = rc;
        if (load_next) begin
            e.row      = pend_row;
            e.k        = int'(rc) % ROW_W;
            e.load_cyc = cyc;
            sb.push_back(e);
            blocked    = e.k + 2;
            load_next  = 1'b0;
        end
        @(negedge clk);
        chk("in_ready", in_ready, blocked == 0);
        chk("busy", busy, blocked != 0);
        @(posedge clk);
        #1;
        acc = 1'b0;
        if (blocked > 0) begin
            blocked--;
        end else if (v) begin
            acc = 1'b1;
            elems.push_back(d);
            if (elems.size() == ROW_W) begin
                for (int i = 0; i < ROW_W; i++) pend_row[i] = elems[i];
                elems.delete();
                load_next = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] rc);
        logic acc;
        int   n = 0;
        do begin
            cycle(1'b1, d, rc, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) flag("send_timeout");
    endtask

    task automatic idle(input int n, input logic [2:0] rc);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'hEE, rc, acc);
    endtask

    task automatic send_row(input logic [7:0] base, input logic [7:0] step,
                            input logic [2:0] rc);
        for (int i = 0; i < ROW_W; i++) send(base + step * 8'(i), rc);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_load", load_en, 0);
        chk("rst_shift", shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < ROW_W; i++) chk("rst_idata", idata[i], 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sb.delete();
        elems.delete();
        blocked   = 0;
        load_next = 1'b0;
    endtask

    initial begin
        logic acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        rot_count = '0;
        do_reset();

        send_row(8'h11, 8'h11, 3'd0);
        idle(4, 3'd0);

        send_row(8'h11, 8'h11, 3'd3);
        idle(6, 3'd3);

        send_row(8'h11, 8'h11, 3'd7);
        idle(5, 3'd7);

        for (int i = 0; i < ROW_W; i++) begin
            cycle(1'b1, 8'h31 + 8'(i), 3'd1, acc);
            cycle(1'b0, 8'hEE, 3'd1, acc);
        end
        idle(4, 3'd1);

        send(8'h01, 3'd0);
        send(8'h02, 3'd0);
        send(8'h03, 3'd0);
        do_reset();
        send_row(8'hA0, 8'h01, 3'd0);
        idle(4, 3'd0);

        send_row(8'h50, 8'h03, 3'd4);
        send_row(8'h70, 8'h05, 3'd2);
        idle(8, 3'd2);

        send_row(8'hC0, 8'h01, 3'd4);
        idle(3, 3'd4);
        do_reset();
        idle(3, 3'd0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, 8'($urandom),
                  3'($urandom_range(0, 7)), acc);
        end
        idle(15, 3'd0);

        chk("sb_empty", sb.size(), 0);
        chk("mon_idle", mon_active, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_feed_ctrl.md
ROW_FEED_CTRL -- requirements
Module: row_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bit width of one row element.
REQ-002 SHALL have parameter ROW_WIDTH, default 5, number of elements per row (minimum 2).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream element valid.
REQ-006 SHALL have port in_data, input, DATA_WIDTH, upstream element.
REQ-007 SHALL have port in_ready, output, 1, element accepted when in_valid && in_ready at a clk edge.
REQ-008 SHALL have port rot_count, input, $clog2(ROW_WIDTH), requested rotations, sampled in LOAD.
REQ-009 SHALL have port parallel_load_en, output, 1, one-cycle row load strobe to the downstream shifting row.
REQ-010 SHALL have port parallel_idata, output, unpacked array [ROW_WIDTH] of DATA_WIDTH, assembled row.
REQ-011 SHALL have port shifting_enable, output, 1, one rotation step per high cycle to the downstream row.
REQ-012 SHALL have port busy, output, 1, high in LOAD, ROTATE, DONE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a row has been loaded and fully rotated.

Function
REQ-014 SHALL implement FSM states COLLECT, LOAD, ROTATE, DONE; all outputs registered or decoded from registered state only.
REQ-015 COLLECT: in_ready=1; each accepted element written to buffer[wr_idx], wr_idx incremented; element 0 is the first accepted.
REQ-016 COLLECT -> LOAD on the cycle that accepts the element at wr_idx == ROW_WIDTH-1; wr_idx returns to 0.
REQ-017 in_valid low in COLLECT: no write, wr_idx held, no state change.
REQ-018 LOAD: exactly one cycle; parallel_load_en=1, shifting_enable=0, in_ready=0; rot_count latched as rot_rem = rot_count mod ROW_WIDTH.
REQ-019 LOAD -> ROTATE if rot_rem != 0, else LOAD -> DONE.
REQ-020 ROTATE: shifting_enable=1 each cycle, rot_rem decremented; exit to DONE after the cycle in which rot_rem == 1; exactly rot_rem high cycles total.
REQ-021 DONE: exactly one cycle; done=1; then -> COLLECT.
REQ-022 parallel_load_en and shifting_enable SHALL never be high in the same cycle.
REQ-023 in_ready SHALL be 0 in LOAD, ROTATE, DONE; in_valid there is ignored and data not consumed.
REQ-024 parallel_idata SHALL equal the buffer contents at all times, stable from LOAD through DONE; never X after first full row.
REQ-025 Latency: last element accepted at edge N -> parallel_load_en high in cycle N+1, done high in cycle N+2+rot_rem.
REQ-026 rot_count changes outside LOAD SHALL have no effect on the current row.

Reset
REQ-027 rst high at a clk edge SHALL force state COLLECT, wr_idx=0, rot_rem=0, regardless of current state (including mid-COLLECT and mid-ROTATE).
REQ-028 Outputs after reset: in_ready=1, parallel_load_en=0, shifting_enable=0, busy=0, done=0, all buffer elements 0.
REQ-029 A partially collected row SHALL be discarded by reset; no load or done pulse follows it.

Structure
REQ-030 State enum type (COLLECT, LOAD, ROTATE, DONE) SHALL live in the shared datapath package, with default DATA_WIDTH/ROW_WIDTH constants.
REQ-031 A sub-module row_collect_buf (write-indexed register array with wr_idx counter and full flag) is natural; FSM and rotation counter stay in row_feed_ctrl.
REQ-032 Output protocol SHALL satisfy the shifting row's control assumption (no simultaneous load and shift) so both bind together in a top-level formal run.

Verification
REQ-033 Feed 0x11,0x22,0x33,0x44,0x55 back-to-back, rot_count=0 -> one load pulse with idata={11,22,33,44,55}, no shift, done one cycle later.
REQ-034 Same row, rot_count=3 -> load pulse, then exactly 3 consecutive shifting_enable cycles, then done; downstream row reads {33,44,55,11,22}.
REQ-035 rot_count=7 (ROW_WIDTH=5) -> exactly 2 shift cycles.
REQ-036 in_valid toggling 1,0,1,0 during collect -> only accepted elements stored; load after the 5th accepted element.
REQ-037 rst asserted after 3 elements, then 5 new elements 0xA0..0xA4 -> single load with {A0,A1,A2,A3,A4}.
REQ-038 in_valid held high during ROTATE -> in_ready=0, no element consumed; next row begins only after done; load/shift never overlap (assertion).
